// File: rtl/fwd_hazard_if.sv
// Decode-side bundle between the issuing instruction and the forwarding/hazard unit.
// The master drives the issue fields and collects the bypass selects and stall.
interface fwd_hazard_if #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned SELW    = 3,
    parameter int unsigned CNTW    = 32
);
    logic                        issue_valid;
    logic [REG_AW-1:0]           issue_rd;
    logic                        issue_wr_en;
    logic                        issue_is_load;
    logic [NUM_SRC*REG_AW-1:0]   src_addr;
    logic [NUM_SRC-1:0]          src_used;
    logic                        stall_ext;
    logic                        flush;
    logic [NUM_SRC*SELW-1:0]     fwd_sel;
    logic                        hazard_stall;
    logic [CNTW-1:0]             stall_count;

    modport master (
        output issue_valid, issue_rd, issue_wr_en, issue_is_load,
               src_addr, src_used, stall_ext, flush,
        input  fwd_sel, hazard_stall, stall_count
    );

    modport slave (
        input  issue_valid, issue_rd, issue_wr_en, issue_is_load,
               src_addr, src_used, stall_ext, flush,
        output fwd_sel, hazard_stall, stall_count
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use interlock: tracks DEPTH in-flight producers and
// drives per-operand bypass selects, the decode stall and a saturating stall counter.
module fwd_hazard_unit #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned SELW     = 3,
    parameter int unsigned CNTW     = 32
) (
    input  logic         clk,
    input  logic         reset,
    fwd_hazard_if.slave  bus
);

    // Index k holds the producer in stage k+1 (index 0 is the youngest).
    logic [DEPTH-1:0]   ent_valid;
    logic [DEPTH-1:0]   ent_load;
    logic [REG_AW-1:0]  ent_rd [DEPTH];

    logic [NUM_SRC-1:0]        lu_flag;
    logic [NUM_SRC-1:0]        found;
    logic [NUM_SRC*SELW-1:0]   sel_next;
    logic                      stall;
    logic [CNTW-1:0]           stall_cnt;

    always_comb begin
        sel_next = '0;
        lu_flag  = '0;
        found    = '0;
        for (int unsigned j = 0; j < NUM_SRC; j++) begin
            if (bus.issue_valid && bus.src_used[j] &&
                bus.src_addr[j*REG_AW +: REG_AW] != '0) begin
                for (int unsigned k = 0; k < DEPTH; k++) begin
                    if (!found[j] && ent_valid[k] &&
                        ent_rd[k] == bus.src_addr[j*REG_AW +: REG_AW]) begin
                        found[j] = 1'b1;
                        // Stage k+1 <= LOAD_LAT: load data not yet available.
                        if (ent_load[k] && k < LOAD_LAT)
                            lu_flag[j] = 1'b1;
                        else
                            sel_next[j*SELW +: SELW] = SELW'(k + 1);
                    end
                end
            end
        end
    end

    assign stall            = (|lu_flag) & bus.issue_valid & ~bus.flush;
    assign bus.fwd_sel      = sel_next;
    assign bus.hazard_stall = stall;
    assign bus.stall_count  = stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_valid <= '0;
            ent_load  <= '0;
            for (int unsigned k = 0; k < DEPTH; k++)
                ent_rd[k] <= '0;
            stall_cnt <= '0;
        end else if (!bus.stall_ext) begin
            for (int unsigned k = 1; k < DEPTH; k++) begin
                ent_valid[k] <= ent_valid[k-1];
                ent_load[k]  <= ent_load[k-1];
                ent_rd[k]    <= ent_rd[k-1];
            end
            // Stalled or flushed issue enters the pipe as a bubble.
            ent_valid[0] <= ~(stall | bus.flush) & bus.issue_valid &
                            bus.issue_wr_en & (bus.issue_rd != '0);
            ent_load[0]  <= bus.issue_is_load;
            ent_rd[0]    <= bus.issue_rd;
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: directed pipeline scenarios plus random issue traffic.
module tb_fwd_hazard_unit;
    localparam int unsigned AW = 5;
    localparam int unsigned D  = 2;
    localparam int unsigned NS = 2;
    localparam int unsigned LL = 1;
    localparam int unsigned SW = 3;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fwd_hazard_if #(.REG_AW(AW), .NUM_SRC(NS), .SELW(SW), .CNTW(CW)) bus ();

    fwd_hazard_unit #(
        .REG_AW(AW), .DEPTH(D), .NUM_SRC(NS), .LOAD_LAT(LL), .SELW(SW), .CNTW(CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          v;
        bit [AW-1:0] rd;
        bit          ld;
    } prod_t;

    typedef struct {
        bit [NS*SW-1:0] fwd;
        bit             stall;
        bit [CW-1:0]    cnt;
    } exp_t;

    prod_t       hist[$];   // hist[0] = most recent accepted producer
    int unsigned m_cnt;
    exp_t        exp_q[$];
    exp_t        got_e;
    int          total = 0;
    int          bad   = 0;

    task automatic model_reset();
        prod_t p;
        p.v = 1'b0; p.rd = '0; p.ld = 1'b0;
        hist.delete();
        for (int i = 0; i < D; i++) hist.push_back(p);
        m_cnt = 0;
    endtask

    task automatic cycle(input bit v, input bit [AW-1:0] rd, input bit wr, input bit ld,
                         input bit [AW-1:0] a0, input bit [AW-1:0] a1, input bit [1:0] used,
                         input bit ext, input bit fl, input bit rst);
        exp_t        e;
        bit [AW-1:0] src [NS];
        bit          any_haz;
        prod_t       p;
        reset             = rst;
        bus.issue_valid   = v;
        bus.issue_rd      = rd;
        bus.issue_wr_en   = wr;
        bus.issue_is_load = ld;
        bus.src_addr      = {a1, a0};
        bus.src_used      = used;
        bus.stall_ext     = ext;
        bus.flush         = fl;
        src[0] = a0;
        src[1] = a1;
        e.fwd  = '0;
        any_haz = 1'b0;
        for (int j = 0; j < NS; j++) begin
            if (v && used[j] && src[j] != 0) begin
                for (int k = 0; k < hist.size(); k++) begin
                    if (hist[k].v && hist[k].rd == src[j]) begin
                        if (hist[k].ld && (k + 1) <= LL) any_haz = 1'b1;
                        else e.fwd[j*SW +: SW] = SW'(k + 1);
                        break;
                    end
                end
            end
        end
        e.stall = any_haz && !fl;
        e.cnt   = CW'(m_cnt);
        exp_q.push_back(e);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (!ext) begin
            p.v  = v && wr && (rd != 0) && !e.stall && !fl;
            p.rd = rd;
            p.ld = ld;
            hist.push_front(p);
            void'(hist.pop_back());
            if (e.stall && m_cnt < (1 << CW) - 1) m_cnt++;
        end
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            got_e = exp_q.pop_front();
            total++;
            if (bus.fwd_sel !== got_e.fwd) begin
                bad++;
                $display("FAIL fwd_sel t=%0t got=%h want=%h", $time, bus.fwd_sel, got_e.fwd);
            end
            total++;
            if (bus.hazard_stall !== got_e.stall) begin
                bad++;
                $display("FAIL hazard_stall t=%0t got=%b want=%b", $time, bus.hazard_stall, got_e.stall);
            end
            total++;
            if (bus.stall_count !== got_e.cnt) begin
                bad++;
                $display("FAIL stall_count t=%0t got=%0d want=%0d", $time, bus.stall_count, got_e.cnt);
            end
        end
    end

    initial begin
        reset             = 1'b1;
        bus.issue_valid   = 1'b0;
        bus.issue_rd      = '0;
        bus.issue_wr_en   = 1'b0;
        bus.issue_is_load = 1'b0;
        bus.src_addr      = '0;
        bus.src_used      = '0;
        bus.stall_ext     = 1'b0;
        bus.flush         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // reset state, then plain ALU forwarding from stages 1 and 2
        idle();
        cycle(1, 5, 1, 0, 0, 0, 2'b00, 0, 0, 0);
        cycle(1, 0, 0, 0, 5, 5, 2'b11, 0, 0, 0);
        cycle(1, 0, 0, 0, 5, 0, 2'b01, 0, 0, 0);
        repeat (3) idle();
        cycle(1, 0, 0, 0, 5, 5, 2'b11, 0, 0, 0);

        // load-use: one stall cycle, then forward from stage 2
        cycle(1, 7, 1, 1, 0, 0, 2'b00, 0, 0, 0);
        cycle(1, 8, 1, 0, 0, 7, 2'b10, 0, 0, 0);
        cycle(1, 8, 1, 0, 0, 7, 2'b10, 0, 0, 0);

        // youngest producer wins; x0 never forwards
        cycle(1, 3, 1, 0, 0, 0, 2'b00, 0, 0, 0);
        cycle(1, 3, 1, 0, 0, 0, 2'b00, 0, 0, 0);
        cycle(1, 0, 0, 0, 3, 3, 2'b11, 0, 0, 0);
        cycle(1, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0);

        // external stall freezes tracker and counter during a hazard
        cycle(1, 9, 1, 1, 0, 0, 2'b00, 0, 0, 0);
        repeat (3) cycle(1, 10, 1, 0, 9, 0, 2'b01, 1, 0, 0);
        cycle(1, 10, 1, 0, 9, 0, 2'b01, 0, 0, 0);
        cycle(1, 10, 1, 0, 9, 0, 2'b01, 0, 0, 0);

        // flush on hazard inserts a bubble without stalling
        cycle(1, 4, 1, 1, 0, 0, 2'b00, 0, 0, 0);
        cycle(1, 11, 1, 0, 4, 4, 2'b11, 0, 1, 0);
        cycle(1, 0, 0, 0, 4, 0, 2'b01, 0, 0, 0);

        // reset mid-stall
        cycle(1, 2, 1, 1, 0, 0, 2'b00, 0, 0, 0);
        cycle(1, 12, 1, 0, 2, 2, 2'b11, 0, 0, 1);
        cycle(1, 12, 1, 0, 2, 2, 2'b11, 0, 0, 0);

        // random traffic on a small register window to provoke hazards and saturation
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom % 10) < 8, AW'($urandom % 8), ($urandom % 10) < 7,
                  ($urandom % 10) < 4, AW'($urandom % 8), AW'($urandom % 8),
                  2'($urandom), ($urandom % 10) == 0, ($urandom % 10) == 0,
                  ($urandom % 200) == 0);
        end

        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
